// File: rtl/ctrl_pio_bank.sv
// ctrl_pio_bank: multi-channel Avalon-MM output PIO.
// Each channel has a DATA register that can be written, set, cleared and toggled.
// Each channel also has a pulse engine that sets bits and clears them again by
// itself after PULSE_LEN cycles.
//
// Ports:
//   clk, reset    single clock; synchronous active-high reset
//   address       {channel, reg[2:0]}
//   chipselect    slave select
//   write_n       active-low write
//   read          active-high read
//   writedata     32-bit write data
//   readdata      32-bit read data, one cycle read latency, held between reads
//   out_port      channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   out_update    one-cycle strobe per channel after its DATA changed
module ctrl_pio_bank #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned PULSE_CNT_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  localparam int unsigned ADDR_WIDTH     = $clog2(NUM_CH) + 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic                         chipselect,
  input  logic                         write_n,
  input  logic                         read,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_port,
  output logic [NUM_CH-1:0]            out_update
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [2:0] RegData   = 3'd0;
  localparam logic [2:0] RegPlen   = 3'd1;
  localparam logic [2:0] RegStatus = 3'd2;
  localparam logic [2:0] RegToggle = 3'd3;
  localparam logic [2:0] RegSet    = 3'd4;
  localparam logic [2:0] RegClear  = 3'd5;
  localparam logic [2:0] RegPulse  = 3'd6;

  localparam logic [PULSE_CNT_WIDTH-1:0] CntOne = PULSE_CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0]      data_q  [NUM_CH];
  logic [DATA_WIDTH-1:0]      data_d  [NUM_CH];
  logic [DATA_WIDTH-1:0]      mask_q  [NUM_CH];
  logic [DATA_WIDTH-1:0]      mask_d  [NUM_CH];
  logic [PULSE_CNT_WIDTH-1:0] cnt_q   [NUM_CH];
  logic [PULSE_CNT_WIDTH-1:0] cnt_d   [NUM_CH];
  logic [PULSE_CNT_WIDTH-1:0] plen_q  [NUM_CH];
  logic [PULSE_CNT_WIDTH-1:0] plen_d  [NUM_CH];
  logic [NUM_CH-1:0]          active_q, active_d;
  logic [NUM_CH-1:0]          update_q, update_d;
  logic [31:0]                readdata_q, readdata_d;

  logic [CH_W-1:0]       ch_sel;
  logic [2:0]            reg_sel;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wd;

  if (NUM_CH > 1) begin : g_multi_ch
    assign ch_sel = address[ADDR_WIDTH-1:3];
  end else begin : g_single_ch
    assign ch_sel = '0;
  end

  assign reg_sel = address[2:0];
  assign wr_en   = chipselect && !write_n;
  assign rd_en   = chipselect && read;
  assign wd      = writedata[DATA_WIDTH-1:0];

  // Expiry is applied first, then the CPU write operates on the result.
  // A CPU write therefore wins over a pulse that expires in the same cycle.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      data_d[c]   = data_q[c];
      mask_d[c]   = mask_q[c];
      cnt_d[c]    = cnt_q[c];
      plen_d[c]   = plen_q[c];
      active_d[c] = active_q[c];

      if (active_q[c]) begin
        if (cnt_q[c] == CntOne) begin
          data_d[c]   = data_q[c] & ~mask_q[c];
          mask_d[c]   = '0;
          cnt_d[c]    = '0;
          active_d[c] = 1'b0;
        end else begin
          cnt_d[c] = cnt_q[c] - CntOne;
        end
      end

      if (wr_en && (ch_sel == CH_W'(c))) begin
        case (reg_sel)
          RegData:   data_d[c] = wd;
          RegPlen:   plen_d[c] = writedata[PULSE_CNT_WIDTH-1:0];
          RegToggle: data_d[c] = data_d[c] ^ wd;
          RegSet:    data_d[c] = data_d[c] | wd;
          RegClear:  data_d[c] = data_d[c] & ~wd;
          RegPulse: begin
            data_d[c]   = data_d[c] | wd;
            mask_d[c]   = mask_d[c] | wd;
            // A stored length of 0 behaves as 1.
            cnt_d[c]    = (plen_q[c] == '0) ? CntOne : plen_q[c];
            active_d[c] = 1'b1;
          end
          default: ;
        endcase
      end

      update_d[c] = (data_d[c] != data_q[c]);
    end
  end

  // Readback samples the current registers, so a simultaneous write to the
  // same register returns the pre-write value.
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      case (reg_sel)
        RegData:   readdata_d = 32'(data_q[ch_sel]);
        RegPlen:   readdata_d = 32'(plen_q[ch_sel]);
        RegStatus: readdata_d = {30'b0, |mask_q[ch_sel], active_q[ch_sel]};
        default:   readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        data_q[c] <= RESET_VALUE;
        mask_q[c] <= '0;
        cnt_q[c]  <= '0;
        plen_q[c] <= CntOne;
      end
      active_q   <= '0;
      update_q   <= '0;
      readdata_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        data_q[c] <= data_d[c];
        mask_q[c] <= mask_d[c];
        cnt_q[c]  <= cnt_d[c];
        plen_q[c] <= plen_d[c];
      end
      active_q   <= active_d;
      update_q   <= update_d;
      readdata_q <= readdata_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign out_port[c*DATA_WIDTH +: DATA_WIDTH] = data_q[c];
  end

  assign out_update = update_q;
  assign readdata   = readdata_q;

endmodule

// File: tb/tb_ctrl_pio_bank.sv
// Directed testbench for ctrl_pio_bank with 4 channels of 32 bits.
// All tasks start and end at a negative clock edge. Inputs change there, and
// outputs are sampled there.
module tb_ctrl_pio_bank;

  localparam int unsigned DW  = 32;
  localparam int unsigned NCH = 4;
  localparam int unsigned PCW = 16;
  localparam logic [31:0] RV  = 32'h0000_00A5;

  logic                clk = 1'b0;
  logic                reset;
  logic [4:0]          address;
  logic                chipselect;
  logic                write_n;
  logic                read;
  logic [31:0]         writedata;
  logic [31:0]         readdata;
  logic [NCH*DW-1:0]   out_port;
  logic [NCH-1:0]      out_update;

  int errors = 0;
  int checks = 0;

  ctrl_pio_bank #(
    .DATA_WIDTH      (DW),
    .NUM_CH          (NCH),
    .PULSE_CNT_WIDTH (PCW),
    .RESET_VALUE     (RV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read       (read),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .out_update (out_update)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] chv(input int c);
    return out_port[c*DW +: DW];
  endfunction

  task automatic wr(input int ch, input int rg, input logic [31:0] wdat);
    address    = 5'((ch << 3) | rg);
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = wdat;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input int ch, input int rg, output logic [31:0] v);
    address    = 5'((ch << 3) | rg);
    chipselect = 1'b1;
    read       = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    read       = 1'b0;
    v          = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_update !== 4'b0) begin
      errors++; $display("FAIL reset_update: got %b want 0000", out_update);
    end
    checks++;
    if (out_port !== {NCH{RV}}) begin
      errors++; $display("FAIL reset_out_port: got %h want %h", out_port, {NCH{RV}});
    end
    for (int c = 0; c < NCH; c++) begin
      rd(c, 0, v);
      checks++;
      if (v !== RV) begin
        errors++; $display("FAIL reset_data ch%0d: got %h want %h", c, v, RV);
      end
      rd(c, 1, v);
      checks++;
      if (v !== 32'd1) begin
        errors++; $display("FAIL reset_plen ch%0d: got %h want 1", c, v);
      end
      checks++;
      if (out_update !== 4'b0) begin
        errors++; $display("FAIL reset_update_idle ch%0d: got %b want 0000", c, out_update);
      end
    end
  endtask

  task automatic test_ch2_ops();
    int          rgs [4] = '{0, 4, 5, 3};
    logic [31:0] wds [4] = '{32'hF0, 32'h0F, 32'h30, 32'h101};
    logic [31:0] exps[4] = '{32'hF0, 32'hFF, 32'hCF, 32'h1CE};
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      wr(2, rgs[i], wds[i]);
      checks++;
      if (chv(2) !== exps[i]) begin
        errors++; $display("FAIL ch2_op%0d data: got %h want %h", i, chv(2), exps[i]);
      end
      checks++;
      if (out_update !== 4'b0100) begin
        errors++; $display("FAIL ch2_op%0d strobe: got %b want 0100", i, out_update);
      end
      checks++;
      if (chv(0) !== RV || chv(1) !== RV || chv(3) !== RV) begin
        errors++; $display("FAIL ch2_op%0d others: got %h want %h", i, out_port, RV);
      end
      @(negedge clk);
      checks++;
      if (out_update !== 4'b0) begin
        errors++; $display("FAIL ch2_op%0d strobe_len: got %b want 0000", i, out_update);
      end
    end
    rd(2, 0, v);
    checks++;
    if (v !== 32'h1CE) begin
      errors++; $display("FAIL ch2_readback: got %h want 000001ce", v);
    end
  endtask

  task automatic test_pulse();
    logic [31:0] exp_out;
    logic [31:0] exp_st;
    logic [3:0]  exp_upd;
    wr(1, 0, 32'h1);
    wr(1, 1, 32'd5);
    wr(1, 6, 32'h4);
    checks++;
    if (chv(1) !== 32'h5 || out_update !== 4'b0010) begin
      errors++; $display("FAIL pulse_start: got data %h upd %b want 5 0010", chv(1), out_update);
    end
    // Read STATUS continuously; each sample shows the state one cycle earlier.
    address    = 5'((1 << 3) | 2);
    chipselect = 1'b1;
    read       = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_out = (k < 5) ? 32'h5 : 32'h1;
      exp_st  = (k <= 5) ? 32'h3 : 32'h0;
      exp_upd = (k == 5) ? 4'b0010 : 4'b0000;
      checks++;
      if (chv(1) !== exp_out) begin
        errors++; $display("FAIL pulse_out k=%0d: got %h want %h", k, chv(1), exp_out);
      end
      checks++;
      if (readdata !== exp_st) begin
        errors++; $display("FAIL pulse_status k=%0d: got %h want %h", k, readdata, exp_st);
      end
      checks++;
      if (out_update !== exp_upd) begin
        errors++; $display("FAIL pulse_strobe k=%0d: got %b want %b", k, out_update, exp_upd);
      end
    end
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  task automatic test_retrigger();
    logic [31:0] exp_out;
    wr(1, 0, 32'h0);
    wr(1, 1, 32'd8);
    wr(1, 6, 32'h1);
    checks++;
    if (chv(1) !== 32'h1) begin
      errors++; $display("FAIL retrig_first: got %h want 1", chv(1));
    end
    repeat (2) @(negedge clk);
    wr(1, 6, 32'h2);
    checks++;
    if (chv(1) !== 32'h3) begin
      errors++; $display("FAIL retrig_second: got %h want 3", chv(1));
    end
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      exp_out = (j < 8) ? 32'h3 : 32'h0;
      checks++;
      if (chv(1) !== exp_out) begin
        errors++; $display("FAIL retrig_hold j=%0d: got %h want %h", j, chv(1), exp_out);
      end
    end
    checks++;
    if (out_update !== 4'b0010) begin
      errors++; $display("FAIL retrig_expiry_strobe: got %b want 0010", out_update);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] v;
    // SET on the expiry edge keeps the bit.
    wr(3, 0, 32'h0);
    wr(3, 1, 32'd2);
    wr(3, 6, 32'h4);
    @(negedge clk);
    wr(3, 4, 32'h4);
    checks++;
    if (chv(3) !== 32'h4 || out_update !== 4'b0) begin
      errors++; $display("FAIL set_on_expiry: got %h upd %b want 4 0000", chv(3), out_update);
    end
    rd(3, 2, v);
    checks++;
    if (v !== 32'h0 || chv(3) !== 32'h4) begin
      errors++; $display("FAIL set_on_expiry_after: got st %h data %h want 0 4", v, chv(3));
    end
    // PULSE_LEN of 0 behaves as 1.
    wr(3, 1, 32'd0);
    rd(3, 1, v);
    checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL plen_zero_read: got %h want 0", v);
    end
    wr(3, 6, 32'h8);
    checks++;
    if (chv(3) !== 32'hC) begin
      errors++; $display("FAIL plen_zero_start: got %h want c", chv(3));
    end
    @(negedge clk);
    checks++;
    if (chv(3) !== 32'h4 || out_update !== 4'b1000) begin
      errors++; $display("FAIL plen_zero_end: got %h upd %b want 4 1000", chv(3), out_update);
    end
    // PULSE on the expiry edge starts with only the new mask.
    wr(0, 0, 32'h0);
    wr(0, 1, 32'd2);
    wr(0, 6, 32'h1);
    @(negedge clk);
    wr(0, 6, 32'h2);
    checks++;
    if (chv(0) !== 32'h2) begin
      errors++; $display("FAIL fresh_pulse_start: got %h want 2", chv(0));
    end
    @(negedge clk);
    checks++;
    if (chv(0) !== 32'h2) begin
      errors++; $display("FAIL fresh_pulse_hold: got %h want 2", chv(0));
    end
    @(negedge clk);
    checks++;
    if (chv(0) !== 32'h0) begin
      errors++; $display("FAIL fresh_pulse_end: got %h want 0", chv(0));
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [31:0] v;
    int          bad_upd;
    wr(0, 0, 32'h0);
    wr(0, 1, 32'd10);
    wr(0, 6, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_port !== {NCH{RV}} || out_update !== 4'b0) begin
      errors++; $display("FAIL midpulse_reset: got %h upd %b want %h 0000", out_port,
                         out_update, {NCH{RV}});
    end
    rd(0, 2, v);
    checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL midpulse_status: got %h want 0", v);
    end
    rd(0, 1, v);
    checks++;
    if (v !== 32'h1) begin
      errors++; $display("FAIL midpulse_plen: got %h want 1", v);
    end
    bad_upd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_update !== 4'b0 || chv(0) !== RV) bad_upd++;
    end
    checks++;
    if (bad_upd != 0) begin
      errors++; $display("FAIL midpulse_no_expiry: got %0d bad cycles want 0", bad_upd);
    end
    rd(0, 7, v);
    checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL read_reserved: got %h want 0", v);
    end
    wr(0, 3, 32'h0);
    rd(0, 3, v);
    checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL read_toggle: got %h want 0", v);
    end
  endtask

  task automatic test_back_to_back();
    // Read and write of the same register in one cycle returns the old value.
    address    = 5'((2 << 3) | 0);
    chipselect = 1'b1;
    read       = 1'b1;
    write_n    = 1'b0;
    writedata  = 32'h77;
    @(negedge clk);
    chipselect = 1'b0;
    read       = 1'b0;
    write_n    = 1'b1;
    checks++;
    if (readdata !== RV || chv(2) !== 32'h77) begin
      errors++; $display("FAIL rd_wr_same: got rd %h data %h want %h 77", readdata, chv(2), RV);
    end
    wr(2, 0, 32'h0);
    wr(2, 4, 32'h1);
    checks++;
    if (chv(2) !== 32'h1 || out_update !== 4'b0100) begin
      errors++; $display("FAIL b2b_set1: got %h upd %b want 1 0100", chv(2), out_update);
    end
    wr(2, 4, 32'h2);
    checks++;
    if (chv(2) !== 32'h3 || out_update !== 4'b0100) begin
      errors++; $display("FAIL b2b_set2: got %h upd %b want 3 0100", chv(2), out_update);
    end
    wr(2, 4, 32'h2);
    checks++;
    if (chv(2) !== 32'h3 || out_update !== 4'b0000) begin
      errors++; $display("FAIL b2b_nochange: got %h upd %b want 3 0000", chv(2), out_update);
    end
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read       = 1'b0;
    writedata  = '0;
    @(negedge clk);
    test_reset();
    test_ch2_ops();
    test_pulse();
    test_retrigger();
    test_simultaneous();
    test_reset_mid_pulse();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pio_bank.md
# ctrl_pio_bank

Parametrised multi-channel Avalon-MM output PIO for the Qsys system: the next generation of the single-register control PIOs that drive filter and peripheral control lines. It provides NUM_CH independent DATA_WIDTH-bit output registers behind one slave, each with write, set, clear and toggle access, plus a hardware auto-clearing pulse mode. A one-cycle update strobe per channel tells downstream logic when its control word changed. Readback uses a registered one-cycle read latency.

## Interface
- DATA_WIDTH, 32, width of each channel's output register (1..32)
- NUM_CH, 4, number of channels (power of two, 1..16)
- PULSE_CNT_WIDTH, 16, width of the per-channel pulse-length counter
- RESET_VALUE, 0, DATA_WIDTH-bit reset value of every channel's DATA register
- ADDR_WIDTH (localparam), clog2(NUM_CH)+3
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- address  in  ADDR_WIDTH  {channel[ADDR_WIDTH-1:3], reg[2:0]}
- chipselect  in  1  slave select
- write_n  in  1  active-low write
- read  in  1  active-high read
- writedata  in  32  write data; bits above DATA_WIDTH ignored
- readdata  out  32  read data, zero-extended, valid the cycle after read
- out_port  out  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- out_update  out  NUM_CH  one-cycle strobe: channel's DATA changed on the previous edge

## Operation
- Write strobe: chipselect && !write_n. Read strobe: chipselect && read. A single strobe affects only the channel selected by address.
- Per-channel registers (reg field):
  - 0 DATA: R/W. The written value replaces the register contents.
  - 1 PULSE_LEN: R/W, PULSE_CNT_WIDTH bits; reset 1. A written value of 0 is stored as 0 but behaves as 1.
  - 2 STATUS: RO. bit0 = pulse_active; bit1 = pulse_mask != 0; bits [31:2] read 0.
  - 3 TOGGLE: WO. DATA ^= wd.
  - 4 SET: WO. DATA |= wd.
  - 5 CLEAR: WO. DATA &= ~wd.
  - 6 PULSE: WO. DATA |= wd; pulse_mask |= wd; counter <= max(PULSE_LEN,1); pulse_active <= 1.
  - 7: reserved. Reads return 0; writes are ignored.
- Write-only registers read 0.
- Pulse engine, per channel:
  - IDLE: pulse_active=0, counter=0, pulse_mask=0.
  - ACTIVE: counter decrements each cycle.
  - Expiry: on the edge where counter==1, apply DATA &= ~pulse_mask, clear pulse_mask, and return to IDLE.
  - Re-trigger while ACTIVE: the new mask ORs into pulse_mask and the counter reloads, so all masked bits expire together.
- Simultaneous expiry and CPU write to the same channel: expiry clear is applied first, then the write operation on the result (write wins).
  - A PULSE write on the expiry cycle starts a fresh pulse with only the new mask.
  - A write to PULSE_LEN during ACTIVE does not affect the running counter.
- out_update[c] asserts for exactly one cycle after any edge where DATA[c] changed value, whether from a write or an expiry. A write that leaves DATA unchanged produces no strobe.
- Reset: DATA=RESET_VALUE, PULSE_LEN=1, pulse_mask=0, counter=0, pulse_active=0, readdata=0, out_update=0. Reset mid-pulse aborts the pulse with no expiry strobe.

## Timing
- A write captured at edge N is visible on out_port after edge N; out_update is high during cycle N+1.
- A read presented at edge N drives readdata after edge N (read latency 1). readdata holds its value until the next read.
  - A read and write in the same cycle to the same register returns the pre-write value.
- Pulse of length L (L≥1) written at edge N:
  - bits are high from edge N to edge N+L, i.e. high for exactly L cycles;
  - STATUS bit0 is high over the same window.
- No wait states; the slave accepts one access per cycle.

## Test plan
- Reset, then read DATA of every channel -> RESET_VALUE; read PULSE_LEN -> 1; out_update stays 0; out_port equals RESET_VALUE replicated per channel.
- Ch2: write DATA=0x0000_00F0, SET 0x0F, CLEAR 0x30, TOGGLE 0x101 -> DATA sequence 0xF0, 0xFF, 0xCF, 0x1CE. Each write produces one out_update[2] pulse one cycle later; other channels unchanged.
- Ch1 PULSE_LEN=5, PULSE 0x4 with DATA=0x1 -> out bits 0x5 for exactly 5 cycles, then 0x1. STATUS bit0 is high for 5 cycles. out_update[1] strobes at start and at expiry.
- Ch1 PULSE_LEN=8, PULSE 0x1, then PULSE 0x2 three cycles later -> 0x3 held for 8 cycles after the second write, then both bits clear on the same edge.
- Simultaneous events: SET 0x4 on the expiry cycle of a pulse with mask 0x4 -> DATA bit2 remains 1. PULSE_LEN=0 with PULSE 0x8 -> bit3 high for exactly 1 cycle.
- Assert reset 2 cycles into a 10-cycle pulse -> DATA=RESET_VALUE and STATUS=0 the next cycle, with no later expiry strobe. Read of reg 7 and of TOGGLE -> 0.
